// File: rtl/mips_issue_ctrl.sv
// mips_issue_ctrl: issue/hazard controller between the IF/ID latch and ID/EX issue.
// Tracks destination registers in flight in EX, MEM and WB. It stalls on a
// read-after-write hazard and kills the ID instruction on a taken branch.
// After HLT issues it drains the pipe and then asserts a sticky `halted`.
// Optional feature macro: MIPS32_FWD_EN. When it is defined, the block selects
// forwarding paths and only a load-use case stalls. When it is undefined, the
// block uses a full scoreboard interlock and ties fwd_a/fwd_b to 00.
module mips_issue_ctrl #(
    parameter int NSLOT = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_rd,
    input  logic             id_is_load,
    input  logic             id_halt,
    input  logic             branch_taken,
    output logic             stall,
    output logic             issue,
    output logic             fetch_en,
    output logic             halted,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    // Slot 0 = EX, slot 1 = MEM, slot 2 = WB
    logic [NSLOT-1:0] v_reg;
    logic [NSLOT-1:0] v_next;
    logic [4:0]       rd_reg  [NSLOT];
    logic [4:0]       rd_next [NSLOT];
    // The load flag is only consulted while the producer sits in EX.
    logic             ld0_reg;

    logic [NSLOT-1:0] match_rs;
    logic [NSLOT-1:0] match_rt;
    logic             hazard;
    logic             flush;

    logic             halt_pend_reg;
    logic             fetch_en_reg;
    logic             halted_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] issue_cnt_reg;

    // Per-slot source matches; R0 never matches
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_match
            assign match_rs[gi] = v_reg[gi] && (rd_reg[gi] == id_rs) && (id_rs != 5'd0);
            assign match_rt[gi] = v_reg[gi] && (rd_reg[gi] == id_rt) && (id_rt != 5'd0);
        end
    endgenerate

    // Hazard detection and forward selection
    always_comb begin
        hazard = 1'b0;
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
`ifdef MIPS32_FWD_EN
        hazard = id_valid & ld0_reg &
                 ((id_uses_rs & match_rs[0]) | (id_uses_rt & match_rt[0]));
        if (match_rs[0] && !ld0_reg)
            fwd_a = 2'b01;
        else if (match_rs[1])
            fwd_a = 2'b10;
        if (match_rt[0] && !ld0_reg)
            fwd_b = 2'b01;
        else if (match_rt[1])
            fwd_b = 2'b10;
`else
        hazard = id_valid & ((id_uses_rs & (|match_rs)) | (id_uses_rt & (|match_rt)));
`endif
    end

`ifdef MIPS32_FWD_EN
    // The WB slot never hazards when forwarding is enabled
    logic unused_wb_match;
    assign unused_wb_match = ^{match_rs[NSLOT-1:2], match_rt[NSLOT-1:2]};
`else
    logic unused_ld;
    assign unused_ld = ld0_reg;
`endif

    // A taken branch has priority over the stall, and a pending halt blocks everything
    assign flush = branch_taken;
    assign stall = hazard & ~flush & ~halt_pend_reg;
    assign issue = id_valid & ~stall & ~flush & ~halt_pend_reg;

    // Next slot contents: a new entry enters EX and older entries move down one stage
    assign v_next[0]  = issue & id_wr_en & (id_rd != 5'd0);
    assign rd_next[0] = id_rd;
    generate
        for (genvar gi = 1; gi < NSLOT; gi++) begin : g_shift
            assign v_next[gi]  = v_reg[gi-1];
            assign rd_next[gi] = rd_reg[gi-1];
        end
    endgenerate

    // Scoreboard register; the slots advance on every edge
    always_ff @(posedge clk1) begin
        if (rst) begin
            v_reg   <= '0;
            ld0_reg <= 1'b0;
            for (int i = 0; i < NSLOT; i++)
                rd_reg[i] <= 5'd0;
        end else begin
            v_reg   <= v_next;
            rd_reg  <= rd_next;
            ld0_reg <= id_is_load;
        end
    end

    // Halt sequencing: the pending-halt state, the fetch enable, and a sticky halted once drained
    always_ff @(posedge clk1) begin
        if (rst) begin
            halt_pend_reg <= 1'b0;
            fetch_en_reg  <= 1'b1;
            halted_reg    <= 1'b0;
        end else begin
            if (issue && id_halt)
                halt_pend_reg <= 1'b1;
            fetch_en_reg <= ~(halt_pend_reg | (issue & id_halt));
            if (halt_pend_reg && (v_reg == '0))
                halted_reg <= 1'b1;
        end
    end

    // Performance counters: the stall count saturates and the issue count wraps
    always_ff @(posedge clk1) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            issue_cnt_reg <= '0;
        end else begin
            if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (issue)
                issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
        end
    end

    assign fetch_en  = fetch_en_reg;
    assign halted    = halted_reg;
    assign stall_cnt = stall_cnt_reg;
    assign issue_cnt = issue_cnt_reg;

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// Testbench for mips_issue_ctrl. The reference model records each issued
// writer together with its issue cycle. An entry's pipeline stage is its age
// in cycles: age 1 = EX, 2 = MEM, 3 = WB.
module tb_mips_issue_ctrl;

    localparam int CNT_W = 16;
`ifdef MIPS32_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic             rst, id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, id_halt, branch_taken;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic             stall, issue, fetch_en, halted;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, issue_cnt;

    mips_issue_ctrl #(.NSLOT(3), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .id_halt(id_halt),
        .branch_taken(branch_taken), .stall(stall), .issue(issue),
        .fetch_en(fetch_en), .halted(halted), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model state
    int cyc = 0;
    int q_cyc[$];
    int q_rd[$];
    bit q_ld[$];
    bit m_hp = 0, m_halted = 0, m_fetch = 1;
    int m_scnt = 0, m_icnt = 0;

    // Comb outputs sampled in the last cycle
    logic       s_stall, s_issue;
    logic [1:0] s_fa, s_fb;

    function automatic bit hit(input int r, input int lo, input int hi, input int need_ld);
        if (r == 0) return 1'b0;
        foreach (q_cyc[i]) begin
            int age;
            age = cyc - q_cyc[i];
            if (age >= lo && age <= hi && q_rd[i] == r && (need_ld < 0 || int'(q_ld[i]) == need_ld))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int fwd_sel(input int r);
        if (!FWD) return 0;
        if (hit(r, 1, 1, 0)) return 1;
        if (hit(r, 2, 2, -1)) return 2;
        return 0;
    endfunction

    function automatic bit src_hazard(input int r);
        if (FWD) return hit(r, 1, 1, 1);
        return hit(r, 1, 3, -1);
    endfunction

    task automatic model_edge(input bit e_stall, input bit e_issue);
        bit empty;
        if (rst) begin
            q_cyc.delete(); q_rd.delete(); q_ld.delete();
            m_hp = 0; m_halted = 0; m_fetch = 1; m_scnt = 0; m_icnt = 0;
        end else begin
            empty = 1'b1;
            foreach (q_cyc[i])
                if (cyc - q_cyc[i] >= 1 && cyc - q_cyc[i] <= 3) empty = 1'b0;
            if (m_hp && empty) m_halted = 1;
            if (e_issue && id_wr_en && id_rd != 0) begin
                q_cyc.push_back(cyc); q_rd.push_back(int'(id_rd)); q_ld.push_back(id_is_load);
            end
            if (e_issue && id_halt) m_hp = 1;
            m_fetch = !m_hp;
            if (e_stall && m_scnt < 65535) m_scnt++;
            if (e_issue) m_icnt = (m_icnt + 1) % 65536;
        end
        cyc++;
        while (q_cyc.size() > 0 && cyc - q_cyc[0] > 3) begin
            void'(q_cyc.pop_front()); void'(q_rd.pop_front()); void'(q_ld.pop_front());
        end
    endtask

    // One clock cycle with the current inputs: check comb, clock, check registered
    task automatic cycle();
        bit haz, es, ei;
        int fa, fb;
        #1;
        s_stall = stall; s_issue = issue; s_fa = fwd_a; s_fb = fwd_b;
        haz = id_valid && ((id_uses_rs && src_hazard(int'(id_rs))) ||
                           (id_uses_rt && src_hazard(int'(id_rt))));
        es = haz && !branch_taken && !m_hp;
        ei = id_valid && !es && !branch_taken && !m_hp;
        fa = fwd_sel(int'(id_rs));
        fb = fwd_sel(int'(id_rt));
        check("stall", stall, es);
        check("issue", issue, ei);
        check("fwd_a", fwd_a, fa);
        check("fwd_b", fwd_b, fb);
        @(posedge clk1);
        model_edge(es, ei);
        #1;
        check("fetch_en", fetch_en, m_fetch);
        check("halted", halted, m_halted);
        check("stall_cnt", stall_cnt, m_scnt);
        check("issue_cnt", issue_cnt, m_icnt);
        $display("cyc %0d rst=%b v=%b rs=%0d rt=%0d rd=%0d br=%b hlt=%b -> stall=%b issue=%b fa=%0d fb=%0d fe=%b halted=%b sc=%0d ic=%0d",
                 cyc, rst, id_valid, id_rs, id_rt, id_rd, branch_taken, id_halt,
                 s_stall, s_issue, s_fa, s_fb, fetch_en, halted, stall_cnt, issue_cnt);
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit wr, input int rd, input bit ld, input bit hlt, input bit br);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_wr_en = wr; id_rd = 5'(rd); id_is_load = ld; id_halt = hlt; branch_taken = br;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
        check("rst_fetch_en", fetch_en, 1);
        check("rst_halted", halted, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_issue_cnt", issue_cnt, 0);
    endtask

    // Producer then immediate consumer ADD R4,rs,rt; count stall cycles until issue
    task automatic dep_test(input string tag, input int prod_rd, input bit prod_ld,
                            input int cons_rs, input int cons_rt, input int exp_stalls, input int exp_fwd);
        int stalls = 0;
        bit issued = 0;
        int fsel = 0;
        do_reset();
        set_in(1, 0, 0, 1, 0, 1, prod_rd, prod_ld, 0, 0);
        cycle();
        check({tag, "_prod_issue"}, s_issue, 1);
        set_in(1, cons_rs, cons_rt, 1, 1, 1, 4, 0, 0, 0);
        for (int k = 0; k < 6 && !issued; k++) begin
            cycle();
            stalls += int'(s_stall);
            if (s_issue) begin issued = 1; fsel = int'(s_fa); end
        end
        idle(); cycle();
        check({tag, "_issued"}, issued, 1);
        check({tag, "_stalls"}, stalls, exp_stalls);
        check({tag, "_fwd_a"}, fsel, exp_fwd);
        check({tag, "_stall_cnt"}, stall_cnt, exp_stalls);
        check({tag, "_issue_cnt"}, issue_cnt, 2);
    endtask

    initial begin
        rst = 1'b0; idle();

        // ADDI R1,R0,10 ; ADD R4,R1,R2
        dep_test("alu_dep", 1, 0, 1, 2, FWD ? 0 : 3, FWD ? 1 : 0);
        // LW R1 ; ADD R4,R1,R2
        dep_test("load_dep", 1, 1, 1, 2, FWD ? 1 : 3, FWD ? 2 : 0);
        // ADDI R0,R0,5 ; ADD R4,R0,R0
        dep_test("r0_dep", 0, 0, 0, 0, 0, 0);

        // Branch taken while a hazard is pending
        do_reset();
        set_in(1, 0, 0, 1, 0, 1, 1, 0, 0, 0); cycle();
        set_in(1, 1, 2, 1, 1, 1, 4, 0, 0, 1); cycle();
        check("br_stall", s_stall, 0);
        check("br_issue", s_issue, 0);
        set_in(1, 4, 4, 1, 1, 1, 6, 0, 0, 0); cycle();
        check("br_bubble_stall", s_stall, 0);
        check("br_bubble_issue", s_issue, 1);
        idle(); cycle();
        check("br_issue_cnt", issue_cnt, 2);
        check("br_stall_cnt", stall_cnt, 0);

        // HLT issues with ADD R5 in EX
        do_reset();
        set_in(1, 1, 2, 1, 1, 1, 5, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
        check("hlt_issue", s_issue, 1);
        check("hlt_fetch_en", fetch_en, 0);
        for (int k = 1; k <= 5; k++) begin
            set_in(1, 10, 11, 1, 1, 1, 12, 0, 0, 0); cycle();
            check("hlt_no_issue", s_issue, 0);
            check("hlt_no_stall", s_stall, 0);
            check("hlt_halted", halted, (k >= 3) ? 1 : 0);
        end

        // Reset pulse during a halt drain
        do_reset();
        set_in(1, 1, 2, 1, 1, 1, 5, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
        idle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check("drain_rst_halted", halted, 0);
        check("drain_rst_fetch_en", fetch_en, 1);
        check("drain_rst_stall_cnt", stall_cnt, 0);
        check("drain_rst_issue_cnt", issue_cnt, 0);
        repeat (4) cycle();
        check("drain_rst_stays", halted, 0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 6),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 6), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_issue_ctrl.md
# mips_issue_ctrl

- Issue/hazard controller for `pipe_MIPS32`; sits between the IF/ID latch and ID/EX issue.
- Keeps a scoreboard of destination registers in flight in EX, MEM and WB.
- Stalls issue and injects a bubble on a read-after-write hazard, kills the ID instruction on a taken branch, and drains the pipe after HLT before asserting `halted`.
- Removes the need for hand-inserted dummy `OR R7,R7,R7` padding in test programs.

## Interface
- `NSLOT`, 3: in-flight tracking slots (EX, MEM, WB).
- `CNT_W`, 16: width of performance counters.
- `clk1`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `id_rs`, `id_rt`  in  5 each  source register fields.
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction reads that source.
- `id_wr_en`  in  1  instruction writes a GPR.
- `id_rd`  in  5  destination register (rd, or rt for I-type and loads; pre-decoded).
- `id_is_load`  in  1  instruction is LW.
- `id_halt`  in  1  instruction is HLT.
- `branch_taken`  in  1  EX resolved a taken branch this cycle.
- `stall`  out  1  combinational; hold PC and IF/ID, send a bubble to EX.
- `issue`  out  1  combinational; ID instruction advances to EX this cycle.
- `fetch_en`  out  1  registered; PC/IF may advance.
- `halted`  out  1  registered; pipe drained after HLT, sticky.
- `fwd_a`, `fwd_b`  out  2 each  combinational forward selects: 00 = RF, 01 = EX/MEM, 10 = MEM/WB.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.
- `issue_cnt`  out  CNT_W  wrapping count of issued instructions.

## Operation
- Each slot is `{v, rd, ld}`. Slot 0 = EX, slot 1 = MEM, slot 2 = WB.
- `match(r)` = (r != 0) and there is a slot with v = 1 and rd == r. R0 never hazards.
- Hazard without forwarding:
  - `id_valid & ((id_uses_rs & match(id_rs)) | (id_uses_rt & match(id_rt)))`.
  - The WB slot counts: an ID read in the same cycle as the WB write sees the old value.
- `flush` = `branch_taken`. Flush has priority over stall.
  - On flush: `stall` = 0, `issue` = 0; the ID instruction is discarded (IF/ID gets a NOP).
- `stall` = hazard & ~flush & ~halt_pend.
- `issue` = id_valid & ~stall & ~flush & ~halt_pend.
- Slot shift every cycle:
  - slot 0 <= `{issue & id_wr_en & (id_rd != 0), id_rd, id_is_load}`; otherwise a bubble (v = 0).
  - slot 1 <= slot 0; slot 2 <= slot 1.
- Halt sequence:
  - When `issue & id_halt`, set halt_pend; `fetch_en` drops on the next cycle.
  - No further issue after halt_pend is set.
  - When halt_pend and all slots have v = 0, `halted` <= 1 on the next edge. It stays 1 until `rst`.
- Counters:
  - `stall_cnt` increments on each `stall` cycle and saturates at all-ones.
  - `issue_cnt` increments on each `issue` and wraps.

## Timing
- Reset values:
  - All slots v = 0; halt_pend = 0.
  - `fetch_en` = 1, `halted` = 0.
  - Both counters = 0.
  - `stall` = 0, `issue` = 0, `fwd_a` = `fwd_b` = 00 while inputs are idle.
- `rst` asserted mid-operation clears everything on that edge, including a pending halt drain.
- Stall/issue/fwd decisions have zero latency, combinational from ID inputs and slot state.
- Slot state, `fetch_en` and `halted` update one edge later.
- Non-forwarded back-to-back dependency (producer issues in cycle t): consumer stalls in cycles t+1..t+3 and issues in t+4.
- A stall is released by slot shifting only; no handshake with downstream.
- If `branch_taken` and a hazard occur together: flush, no stall, and `stall_cnt` does not increment.

## Configuration
- `MIPS32_FWD_EN` defined — forwarding mode:
  - Hazard is only a load-use case: slot 0 v & ld & rd matches a used source. This gives at most a 1-cycle stall.
  - `fwd_x` = 01 if slot 0 (non-load) matches the source; else 10 if slot 1 matches; else 00. The nearest slot wins.
  - The WB slot never hazards.
- `MIPS32_FWD_EN` undefined — full scoreboard interlock as described in Operation; `fwd_a`/`fwd_b` tied to 00.

## Test plan
- Reset, then issue ADDI R1,R0,10 followed immediately by ADD R4,R1,R2 (no fwd) -> `stall` high for exactly 3 cycles, `stall_cnt` = 3, `issue_cnt` = 2.
- Same program with `MIPS32_FWD_EN` -> no stall; `fwd_a` = 01 on the ADD issue cycle. LW R1 then ADD R4,R1,R2 -> 1 stall cycle, then `fwd_a` = 10.
- ADDI R0,R0,5 then ADD R4,R0,R0 -> no stall (R0 exempt).
- Hazard pending while `branch_taken` = 1 -> `stall` = 0, `issue` = 0, and slot 0 is a bubble next cycle.
- HLT issues with ADD R5 in EX -> `fetch_en` = 0 next cycle; `halted` = 1 after slots drain (4 edges); later `id_valid` pulses are not issued.
- `rst` pulse one cycle during a halt drain -> `halted` = 0, `fetch_en` = 1, counters = 0 on the next cycle.
